// File: rtl/mult8_seq_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential 8x8 multiplier: FSM state encoding,
// datapath widths and the per-step shift applied to each 4x4 partial product.
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int STEP_W = 2;
    localparam int OPND_W = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SHIFT_STEP0 = 4'd0;
    localparam logic [3:0] SHIFT_STEP1 = 4'd4;
    localparam logic [3:0] SHIFT_STEP2 = 4'd4;
    localparam logic [3:0] SHIFT_STEP3 = 4'd8;

    // Weight of the partial product: lo*lo = 0, cross terms = 4, hi*hi = 8.
    function automatic logic [3:0] stepShift(input logic [STEP_W-1:0] step);
        logic [3:0] shiftAmt;
        case (step)
            2'd0:    shiftAmt = SHIFT_STEP0;
            2'd1:    shiftAmt = SHIFT_STEP1;
            2'd2:    shiftAmt = SHIFT_STEP2;
            default: shiftAmt = SHIFT_STEP3;
        endcase
        return shiftAmt;
    endfunction

endpackage

// File: rtl/mult8_seq_mult4.sv
// -----------------------------------------------------------------------------
// Mult4
// Purely combinational 4x4 unsigned multiplier shared across the four steps
// of an 8x8 multiplication.
//   i_a  in  4   multiplicand nibble
//   i_b  in  4   multiplier nibble
//   o_p  out 8   product
// -----------------------------------------------------------------------------
module Mult4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);

    assign o_p = {4'b0000, i_a} * {4'b0000, i_b};

endmodule

// File: rtl/mult8_seq.sv
// -----------------------------------------------------------------------------
// mult8_seq
// Sequential 8x8 unsigned multiplier. One operand pair is accepted through a
// valid/ready handshake, four 4x4 partial products are accumulated over four
// cycles through a single Mult4, and the 16-bit product is offered through a
// valid/ready output handshake.
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operands on a/b are valid
//   in_ready   out  1   idle, can accept operands
//   a          in   8   multiplicand
//   b          in   8   multiplier
//   out_valid  out  1   product valid
//   out_ready  in   1   consumer takes product
//   product    out  16  accumulator
//   busy       out  1   multiplying or holding a result
// -----------------------------------------------------------------------------
module mult8_seq
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);

    state_t              r_state;
    state_t              w_nextState;
    logic [STEP_W-1:0]   r_step;
    logic [OPND_W-1:0]   r_a;
    logic [OPND_W-1:0]   r_b;
    logic [PROD_W-1:0]   r_acc;

    logic [3:0]          w_multA;
    logic [3:0]          w_multB;
    logic [7:0]          w_pp;
    logic [PROD_W-1:0]   w_ppExt;
    logic [PROD_W-1:0]   w_addend;

    // step[1] picks the multiplicand nibble, step[0] the multiplier nibble,
    // giving lo*lo, lo*hi, hi*lo, hi*hi for steps 0..3.
    assign w_multA = r_step[1] ? r_a[7:4] : r_a[3:0];
    assign w_multB = r_step[0] ? r_b[7:4] : r_b[3:0];

    Mult4 u_mult4 (
        .i_a (w_multA),
        .i_b (w_multB),
        .o_p (w_pp)
    );

    assign w_ppExt  = {8'b0, w_pp};
    assign w_addend = w_ppExt << stepShift(r_step);

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)       w_nextState = S_MUL;
            S_MUL:   if (r_step == 2'd3) w_nextState = S_DONE;
            S_DONE:  if (out_ready)      w_nextState = S_IDLE;
            default:                     w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Operand capture on accept, then one accumulate per MUL cycle. The
    // result is left in r_acc after retire until the next accept clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_acc  <= '0;
                        r_step <= '0;
                    end
                end
                S_MUL: begin
                    r_acc  <= r_acc + w_addend;
                    r_step <= r_step + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_MUL) || (r_state == S_DONE);
    assign product   = r_acc;

endmodule

// File: tb/tb_mult8_seq.sv
// -----------------------------------------------------------------------------
// tb_mult8_seq
// Directed bench for mult8_seq: basic per-edge accumulation, corner operands,
// output backpressure, back-to-back random stream and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_mult8_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int assertCount = 0;
    int failCount   = 0;

    mult8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present operands at a falling edge, wait (bounded) for in_ready, let the
    // accept edge pass and drop in_valid. Returns at the falling edge after accept.
    task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB);
        int waited;
        @(negedge clk);
        a        = opA;
        b        = opB;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'hXX ^ 8'hXX;
        b        = 8'h00;
    endtask

    // Wait (bounded) for out_valid, compare product, then retire it.
    task automatic finishOp(input string tag, input logic [15:0] expected);
        int waited;
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput(tag, 32'(product), 32'(expected));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [15:0] basicSteps [4] = '{16'h0054, 16'h01A4, 16'h0924, 16'h2724};
    logic [7:0]  cornerA    [4] = '{8'hFF, 8'h00, 8'h01, 8'h10};
    logic [7:0]  cornerB    [4] = '{8'hFF, 8'h5A, 8'h80, 8'h10};
    logic [15:0] cornerP    [4] = '{16'hFE01, 16'h0000, 16'h0080, 16'h0100};

    initial begin
        logic [15:0] heldProduct;
        logic [15:0] expProd;
        logic [7:0]  curA;
        logic [7:0]  curB;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;

        // Reset values, in_ready high while still in reset
        #12;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_product", 32'(product), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic 0xA7 * 0x3C with per-edge accumulator values
        applyStimulus(8'hA7, 8'h3C);
        checkOutput("basic_busy", 32'(busy), 32'd1);
        checkOutput("basic_acc_clear", 32'(product), 32'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("basic_valid_early", 32'(out_valid), 32'd0);
            @(negedge clk);
            checkOutput($sformatf("basic_acc_edge%0d", i + 1), 32'(product), 32'(basicSteps[i]));
        end
        checkOutput("basic_valid_c5", 32'(out_valid), 32'd1);
        checkOutput("basic_in_ready_done", 32'(in_ready), 32'd0);
        finishOp("basic_product", 16'h2724);
        checkOutput("basic_idle", 32'(in_ready), 32'd1);
        checkOutput("basic_hold_after_retire", 32'(product), 32'h2724);

        // Corner operands
        for (int i = 0; i < 4; i++) begin
            applyStimulus(cornerA[i], cornerB[i]);
            finishOp($sformatf("corner%0d", i), cornerP[i]);
        end

        // Backpressure: hold out_ready low while a new request waits
        applyStimulus(8'h0F, 8'h0E);
        repeat (4) @(negedge clk);
        heldProduct = 16'h00D2;
        a        = 8'h12;
        b        = 8'h34;
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_product", 32'(product), 32'(heldProduct));
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp_retired", 32'(out_valid), 32'd0);
        checkOutput("bp_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp_accept_clear", 32'(product), 32'h0);
        finishOp("bp_new_product", 16'h03A8);

        // Back-to-back stream: in_valid and out_ready held high
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 8'($urandom_range(0, 255));
        b         = 8'($urandom_range(0, 255));
        for (int i = 0; i < 1000; i++) begin
            checkOutput("b2b_ready", 32'(in_ready), 32'd1);
            curA = a;
            curB = b;
            expProd = 16'(curA) * 16'(curB);
            @(posedge clk);
            @(negedge clk);
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            repeat (3) @(posedge clk);
            @(negedge clk);
            checkOutput("b2b_not_yet", 32'(out_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
            checkOutput("b2b_product", 32'({out_valid, product}), 32'({1'b1, expProd}));
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        // Reset while step == 2
        applyStimulus(8'h55, 8'hAA);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_product", 32'(product), 32'h0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        applyStimulus(8'h03, 8'h05);
        finishOp("midrst_next", 16'h000F);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
